// File: rtl/hfrv_uart_pkg.sv
// Shared types and register map constants for the hfrv memory-mapped UART transmitter.
package hfrv_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef HFRV_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic [31:0] UART_DATA_OFS   = 32'd0;
    localparam logic [31:0] UART_STATUS_OFS = 32'd4;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_EMPTY_BIT = 3;

endpackage

// File: rtl/hfrv_sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is combinational from the head entry.
// Latency: a push is visible (empty deasserts) after the pushing edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module hfrv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hfrv_uart_tx.sv
// Memory-mapped UART transmitter, 8N1 (8E1 when HFRV_UART_TX_PARITY_EN is defined).
// Latency: tx_o falls one idle cycle after the DATA write; frames are sent back-to-back.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flag sticky overflow.
module hfrv_uart_tx
    import hfrv_uart_pkg::*;
#(
    parameter logic [31:0] UART_ADDR  = 32'hE100_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  we_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

    uart_tx_state_t         state, state_nxt;
    logic [BW-1:0]          baud, baud_nxt;
    logic [2:0]             bit_idx, bit_nxt;
    logic [7:0]             shreg, shreg_nxt;
    logic                   tx;
    logic                   pop;
    logic                   overflow;
    logic                   data_wr;
    logic                   status_wr;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [7:0]             fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                   unused_data;

    assign unused_data = ^data_i[31:8];
    assign data_wr     = (we_i != 4'b0000) && (addr_i == UART_ADDR + UART_DATA_OFS);
    assign status_wr   = (we_i != 4'b0000) && (addr_i == UART_ADDR + UART_STATUS_OFS);

    hfrv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (data_wr),
        .din     (data_i[7:0]),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (status_wr) begin
            overflow <= 1'b0;
        end else if (data_wr && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        pop       = 1'b0;
        tx        = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_nxt = fifo_dout;
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (baud == '0) begin
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = 3'd0;
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud - 1'b1;
                end
            end
            ST_DATA: begin
                tx = shreg[bit_idx];
                if (baud == '0) begin
                    baud_nxt = BAUD_RELOAD;
                    bit_nxt  = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef HFRV_UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end else begin
                    baud_nxt = baud - 1'b1;
                end
            end
`ifdef HFRV_UART_TX_PARITY_EN
            ST_PARITY: begin
                tx = ^shreg;
                if (baud == '0) begin
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = ST_STOP;
                end else begin
                    baud_nxt = baud - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx = 1'b1;
                if (baud == '0) begin
                    // Chain straight into the next start bit so queued bytes leave without an idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_nxt = fifo_dout;
                        baud_nxt  = BAUD_RELOAD;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    baud_nxt = baud - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx_o   = tx;
    assign busy_o = (state != ST_IDLE) || (fifo_count != '0);

    always_comb begin
        data_o = 32'd0;
        if (addr_i == UART_ADDR + UART_STATUS_OFS) begin
            data_o[STAT_BUSY_BIT]  = busy_o;
            data_o[STAT_FULL_BIT]  = fifo_full;
            data_o[STAT_OVF_BIT]   = overflow;
            data_o[STAT_EMPTY_BIT] = (fifo_count == '0);
        end
    end

endmodule
